instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of out_addr.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_class  in  4  0=R, 1=I, 2=L, 3=S, 4=B, 5=LUI, 6=AUIPC, 7=JAL, 8=JALR.
- in_funct3  in  3  funct3.
- in_funct7b5  in  1  instr[30] for R and shift-immediate.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  immediate; byte offset for B and JAL.
- out_valid  out  1  instruction word available.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_instr  out  32  encoded RV32I word.
- out_addr  out  ADDR_W  word address of out_instr.
- out_err  out  1  field error on current word.

Function
REQ-003 SHALL encode combinationally on accept and push the word into a 2-entry FIFO.
- Output is the FIFO head; latency accept -> out_valid is 1 cycle when the FIFO is empty.
REQ-004 SHALL drive in_ready = (count < 2) & ~clear.
- No full-bypass: with count==2 and a pop in the same cycle, in_ready stays 0.
REQ-005 SHALL drive out_valid = (count != 0).
- Simultaneous push and pop at count==1 keeps count at 1, head advances, order preserved.
REQ-006 SHALL encode R as {0,funct7b5,00000, rs2, rs1, funct3, rd, 0110011}.
REQ-007 SHALL encode I as {imm[11:0], rs1, funct3, rd, 0010011}.
- For funct3 001/101, bits[31:25] = {0,funct7b5,00000} and bits[24:20] = imm[4:0].
REQ-008 SHALL encode L as {imm[11:0], rs1, funct3, rd, 0000011}.
REQ-009 SHALL encode S as {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
REQ-010 SHALL encode B as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
REQ-011 SHALL encode LUI and AUIPC as {imm[31:12], rd, opcode}, with opcodes 0110111 and 0010111.
REQ-012 SHALL encode JAL as {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
REQ-013 SHALL encode JALR as {imm[11:0], rs1, 000, rd, 1100111}; in_funct3 is ignored.
REQ-014 SHALL encode in_class > 8 as NOP 0x00000013 with out_err=1.
REQ-015 SHALL keep an ADDR_W-bit address counter, presented on out_addr.
- Increments on each pop; wraps from 2^ADDR_W-1 to 0.
REQ-016 SHALL, on clear, on the next edge:
- empty the FIFO and zero the address counter;
- discard any same-cycle push or pop.

Reset
REQ-017 SHALL, while rst_n=0, asynchronously force:
- count=0, address counter=0;
- out_valid=0, out_instr=0, out_err=0, out_addr=0.
REQ-018 SHALL discard all in-flight words on reset mid-operation.
- in_ready=1 from the first edge after rst_n deasserts.

Configuration
REQ-019 SHALL, with INSTR_ENC_CHECK_EN defined, set out_err=1 for a word whose in_imm is outside its format:
- I/L/S/JALR: not a sign-extended 12-bit value.
- Shift-immediate: imm[31:5] nonzero.
- B: bit0 set or outside 13-bit signed range.
- JAL: bit0 set or outside 21-bit signed range.
- LUI/AUIPC: imm[11:0] nonzero.
- The word is still encoded per REQ-006..013 from truncated fields.
REQ-020 SHALL, without INSTR_ENC_CHECK_EN, check only REQ-014.
- Immediates are silently truncated.

Verification
REQ-021 SHALL cover these directed scenarios:
- Class 1, f3=0, rd=1, rs1=0, imm=5 -> 0x00500093, out_addr=0, one cycle after accept.
- Class 0, rd=3, rs1=1, rs2=2, funct7b5 0 then 1 -> 0x002081B3 then 0x402081B3, out_addr 0 then 1.
- S f3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423; B f3=0, rs1=1, rs2=2, imm=8 -> 0x00208463; JAL rd=1, imm=16 -> 0x010000EF; LUI rd=5, imm=0x12345000 -> 0x123452B7.
- out_ready=0, three pushes -> in_ready=0 after second; raise out_ready -> words drain in order, addresses consecutive.
- ADDR_W=2, five pops -> out_addr 0,1,2,3,0; clear or rst_n low mid-stream -> out_valid=0 next cycle, next word at out_addr 0.
- in_class=9 -> 0x00000013 with out_err=1; with INSTR_ENC_CHECK_EN, B imm=7 -> out_err=1, without -> out_err=0.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction word encoder feeding a 2-entry output FIFO with a word-address counter.
// Optional immediate range checking is enabled by defining INSTR_ENC_CHECK_EN.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  typedef enum logic [3:0] {
    CLS_R     = 4'd0,
    CLS_I     = 4'd1,
    CLS_L     = 4'd2,
    CLS_S     = 4'd3,
    CLS_B     = 4'd4,
    CLS_LUI   = 4'd5,
    CLS_AUIPC = 4'd6,
    CLS_JAL   = 4'd7,
    CLS_JALR  = 4'd8
  } cls_e;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        is_shift;

  always_comb begin
    enc_instr = 32'h0000_0013;
    enc_err   = 1'b0;
    is_shift  = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    case (in_class)
      CLS_R:     enc_instr = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      CLS_I:
        if (is_shift)
          enc_instr = {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      CLS_L:     enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      CLS_S:     enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      CLS_B:     enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], 7'b1100011};
      CLS_LUI:   enc_instr = {in_imm[31:12], in_rd, 7'b0110111};
      CLS_AUIPC: enc_instr = {in_imm[31:12], in_rd, 7'b0010111};
      CLS_JAL:   enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      CLS_JALR:  enc_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      default: begin
        enc_instr = 32'h0000_0013;
        enc_err   = 1'b1;
      end
    endcase
  end

  logic enc_err_full;

`ifdef INSTR_ENC_CHECK_EN
  logic imm_bad;
  logic sext12_ok;
  logic sext13_ok;
  logic sext21_ok;

  always_comb begin
    sext12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    sext13_ok = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    sext21_ok = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    imm_bad   = 1'b0;
    case (in_class)
      CLS_I:            imm_bad = is_shift ? (|in_imm[31:5]) : ~sext12_ok;
      CLS_L, CLS_S,
      CLS_JALR:         imm_bad = ~sext12_ok;
      CLS_B:            imm_bad = in_imm[0] | ~sext13_ok;
      CLS_JAL:          imm_bad = in_imm[0] | ~sext21_ok;
      CLS_LUI,
      CLS_AUIPC:        imm_bad = |in_imm[11:0];
      default:          imm_bad = 1'b0;
    endcase
    enc_err_full = enc_err | imm_bad;
  end
`else
  always_comb enc_err_full = enc_err;
`endif

  // FIFO entries hold {err, instr}; pointers are 1 bit for the 2-entry depth.
  logic [32:0]       mem_q [2];
  logic [32:0]       mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              push;
  logic              pop;

  assign in_ready  = (count_q != 2'd2) & ~clear;
  assign out_valid = (count_q != 2'd0);
  assign out_instr = out_valid ? mem_q[rd_ptr_q][31:0] : '0;
  assign out_err   = out_valid & mem_q[rd_ptr_q][32];
  assign out_addr  = addr_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    if (clear) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
      addr_d   = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {enc_err_full, enc_instr};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        addr_d   = addr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      addr_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
    end
  end

endmodule
